text_writer: RTL and testbench
==============================

TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 Parameter COLS, default 80, characters per text row.
REQ-002 Parameter ROWS, default 25, text rows per screen.
REQ-003 Parameter BLANK_CHAR, default 8'h20, fill code for cleared cells.
REQ-004 Port clk  in  1  single system clock; all logic on rising edge.
REQ-005 Port rst_n_i  in  1  asynchronous active-low reset.
REQ-006 Port char_i  in  8  character code from stream source.
REQ-007 Port char_valid_i  in  1  char_i valid.
REQ-008 Port char_ready_o  out  1  block accepts char_i this cycle.
REQ-009 Port ram_grant_i  in  1  display in blanking; writer may drive screen RAM.
REQ-010 Port ram_addr_o  out  12  screen RAM address {row[4:0], col[6:0]}.
REQ-011 Port ram_data_o  out  8  write data.
REQ-012 Port ram_wren_o  out  1  write enable.
REQ-013 Port ram_q_i  in  8  RAM read data, valid one clk after address presented.
REQ-014 Port cursor_col_o  out  7  current column.
REQ-015 Port cursor_row_o  out  5  current row.
REQ-016 Port busy_o  out  1  high whenever state is not IDLE.

Function
REQ-017 Transfer SHALL occur when char_valid_i and char_ready_o are both high; char_ready_o SHALL be high only in IDLE.
REQ-018 States: IDLE, PUT, SCROLL_RD, SCROLL_WR, CLEAR; one transfer moves IDLE->PUT (printable, BS) or IDLE->CLEAR (FF) or updates cursor in IDLE (CR, LF without scroll).
REQ-019 ram_wren_o SHALL be asserted only in a cycle where ram_grant_i is high; without grant every state holds, no progress.
REQ-020 Printable (any code other than 8'h08, 8'h0A, 8'h0C, 8'h0D): PUT writes char at {row,col} for exactly one granted cycle, then col+1.
REQ-021 col reaching COLS SHALL set col=0 and advance row.
REQ-022 8'h0D (CR): col=0, no RAM write, remains IDLE.
REQ-023 8'h0A (LF): advance row, col unchanged.
REQ-024 8'h08 (BS): if col>0, col-1 then PUT writes BLANK_CHAR at new col without advancing; if col=0, no-op.
REQ-025 8'h0C (FF): CLEAR writes BLANK_CHAR to all COLS*ROWS cells, then cursor (0,0).
REQ-026 Advancing row from ROWS-1 SHALL trigger scroll: row stays ROWS-1, state SCROLL_RD.
REQ-027 Scroll: for every cell of rows 1..ROWS-1, SCROLL_RD presents source address, SCROLL_WR writes ram_q_i to same col at row-1; then CLEAR fills row ROWS-1 only; then IDLE.
REQ-028 If ram_grant_i is low in SCROLL_WR or was low in the preceding SCROLL_RD cycle, block SHALL return to SCROLL_RD for the same cell.
REQ-029 Cursor outputs SHALL reflect the registered cursor; ram outputs registered.

Reset
REQ-030 On rst_n_i low: state IDLE, cursor (0,0), ram_wren_o 0, ram_addr_o 0, ram_data_o 0, busy_o 0, char_ready_o 1 after release.
REQ-031 Reset mid-scroll or mid-clear SHALL abort immediately; partially updated RAM is not restored.

Configuration
REQ-032 Macro TEXT_WRITER_SCROLL_EN defined: scroll per REQ-026..028.
REQ-033 Macro undefined: advancing row from ROWS-1 sets row=0, then CLEAR fills row 0 only; SCROLL states absent.

Structure
REQ-034 Package text_mode_pkg SHALL hold COLS/ROWS defaults, BLANK_CHAR, control codes (CHR_BS, CHR_LF, CHR_FF, CHR_CR) and the state enum.
REQ-035 Sub-module text_cursor SHALL own col/row registers and advance/wrap/back logic; the FSM and RAM sequencing stay in text_writer.

Verification
REQ-036 Reset, grant high, send 8'h41 -> one write addr 12'h000 data 8'h41; cursor (1,0).
REQ-037 Cursor (79,3), send 8'h42 -> write addr {5'd3,7'd79}; cursor (0,4).
REQ-038 Cursor (5,2), send 8'h08 -> write 8'h20 at {2,4}; cursor (4,2); then 8'h0D -> cursor (0,2), no write.
REQ-039 Cursor (0,24), row 1 pre-filled 8'h55, send 8'h0A with SCROLL_EN -> row 0 reads 8'h55, row 24 all 8'h20, cursor (0,24); without macro -> cursor (0,0), row 0 all 8'h20.
REQ-040 Grant toggled 1 cycle high / 3 low during FF clear -> wren never high while grant low; all 2000 cells 8'h20; cursor (0,0).
REQ-041 Assert rst_n_i low mid-scroll -> wren 0 same cycle, busy_o 0, cursor (0,0), ready high after release.

Source files
------------

// File: rtl/text_mode_pkg.sv
// Shared constants and FSM state type for the text_writer slice.
// The scroll states exist only when TEXT_WRITER_SCROLL_EN is defined.
package text_mode_pkg;
    localparam int unsigned COLS_DEFAULT = 80;
    localparam int unsigned ROWS_DEFAULT = 25;
    localparam logic [7:0]  BLANK_CHAR   = 8'h20;

    localparam logic [7:0] CHR_BS = 8'h08;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_FF = 8'h0C;
    localparam logic [7:0] CHR_CR = 8'h0D;

`ifdef TEXT_WRITER_SCROLL_EN
    typedef enum logic [2:0] {ST_IDLE, ST_PUT, ST_SCROLL_RD, ST_SCROLL_WR, ST_CLEAR} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_PUT, ST_CLEAR} state_t;
`endif
endpackage

// File: rtl/text_cursor.sv
// Cursor position register with column advance/wrap, line feed and backspace.
// TEXT_WRITER_SCROLL_EN: row pins at ROWS-1 on advance; otherwise it wraps to 0.
module text_cursor
    import text_mode_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEFAULT,
    parameter int unsigned ROWS = ROWS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n_i,
    input  logic       i_home,
    input  logic       i_cr,
    input  logic       i_inc,
    input  logic       i_lf,
    input  logic       i_back,
    output logic [6:0] o_col,
    output logic [4:0] o_row,
    output logic       o_last_col,
    output logic       o_last_row
);
    logic [6:0] r_col;
    logic [4:0] r_row;
    logic [4:0] w_row_adv;

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_last_col = (r_col == 7'(COLS - 1));
    assign o_last_row = (r_row == 5'(ROWS - 1));

    always_comb begin
        w_row_adv = r_row + 5'd1;
        if (o_last_row) begin
`ifdef TEXT_WRITER_SCROLL_EN
            w_row_adv = r_row;
`else
            w_row_adv = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_home) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_cr) begin
            r_col <= '0;
        end else if (i_lf) begin
            r_row <= w_row_adv;
        end else if (i_back) begin
            if (r_col != '0) r_col <= r_col - 7'd1;
        end else if (i_inc) begin
            if (o_last_col) begin
                r_col <= '0;
                r_row <= w_row_adv;
            end else begin
                r_col <= r_col + 7'd1;
            end
        end
    end
endmodule

// File: rtl/text_writer.sv
// Character-stream writer into a text-mode screen RAM (put, BS, CR, LF, FF clear).
// Optional TEXT_WRITER_SCROLL_EN: scroll the screen up instead of wrapping to row 0.
module text_writer
    import text_mode_pkg::*;
#(
    parameter int unsigned COLS       = COLS_DEFAULT,
    parameter int unsigned ROWS       = ROWS_DEFAULT,
    parameter logic [7:0]  BLANK_CHAR = text_mode_pkg::BLANK_CHAR
) (
    input  logic        clk,
    input  logic        rst_n_i,
    input  logic [7:0]  char_i,
    input  logic        char_valid_i,
    output logic        char_ready_o,
    input  logic        ram_grant_i,
    output logic [11:0] ram_addr_o,
    output logic [7:0]  ram_data_o,
    output logic        ram_wren_o,
    input  logic [7:0]  ram_q_i,
    output logic [6:0]  cursor_col_o,
    output logic [4:0]  cursor_row_o,
    output logic        busy_o
);
    state_t      r_state, w_next;
    logic [11:0] r_addr;
    logic [7:0]  r_data;
    logic [4:0]  r_end_row;
    logic        r_full, r_put_adv;
    logic        w_xfer, w_is_bs, w_is_lf, w_is_ff, w_is_cr, w_is_prt;
    logic [6:0]  w_col;
    logic [4:0]  w_row;
    logic        w_last_col, w_last_row, w_wrap_bottom, w_bottom_go, w_clr_last;
    logic        w_home, w_cr, w_inc, w_lf, w_back;
    logic [11:0] w_clr_next;
`ifdef TEXT_WRITER_SCROLL_EN
    localparam state_t ST_BOTTOM = ST_SCROLL_RD;
    logic r_phase;
    logic w_scr_last;
    assign w_scr_last = (r_addr[6:0] == 7'(COLS - 1)) && (r_addr[11:7] == 5'(ROWS - 2));
`else
    localparam state_t ST_BOTTOM = ST_CLEAR;
    logic w_unused_q;
    assign w_unused_q = ^ram_q_i;
`endif

    text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk(clk), .rst_n_i(rst_n_i), .i_home(w_home), .i_cr(w_cr), .i_inc(w_inc),
        .i_lf(w_lf), .i_back(w_back), .o_col(w_col), .o_row(w_row),
        .o_last_col(w_last_col), .o_last_row(w_last_row)
    );

    assign w_xfer   = char_valid_i && (r_state == ST_IDLE);
    assign w_is_bs  = (char_i == CHR_BS);
    assign w_is_lf  = (char_i == CHR_LF);
    assign w_is_ff  = (char_i == CHR_FF);
    assign w_is_cr  = (char_i == CHR_CR);
    assign w_is_prt = !(w_is_bs || w_is_lf || w_is_ff || w_is_cr);
    assign w_wrap_bottom = r_put_adv && w_last_col && w_last_row;
    assign w_bottom_go   = (w_xfer && w_is_lf && w_last_row) ||
                           ((r_state == ST_PUT) && ram_grant_i && w_wrap_bottom);
    assign w_clr_last = (r_addr[6:0] == 7'(COLS - 1)) && (r_addr[11:7] == r_end_row);
    assign w_clr_next = (r_addr[6:0] == 7'(COLS - 1)) ? {r_addr[11:7] + 5'd1, 7'd0}
                                                      : {r_addr[11:7], r_addr[6:0] + 7'd1};
    assign ram_addr_o   = r_addr;
    assign ram_data_o   = r_data;
    assign cursor_col_o = w_col;
    assign cursor_row_o = w_row;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_xfer) begin
                if (w_is_ff)                               w_next = ST_CLEAR;
                else if (w_is_prt || (w_is_bs && w_col != '0)) w_next = ST_PUT;
                else if (w_is_lf && w_last_row)            w_next = ST_BOTTOM;
            end
            ST_PUT:   if (ram_grant_i) w_next = w_wrap_bottom ? ST_BOTTOM : ST_IDLE;
            ST_CLEAR: if (ram_grant_i && w_clr_last) w_next = ST_IDLE;
`ifdef TEXT_WRITER_SCROLL_EN
            ST_SCROLL_RD: if (ram_grant_i && r_phase) w_next = ST_SCROLL_WR;
            ST_SCROLL_WR: w_next = (ram_grant_i && w_scr_last) ? ST_CLEAR : ST_SCROLL_RD;
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    // Write enable is gated by grant in the same cycle so no write can land outside blanking.
    always_comb begin
        char_ready_o = (r_state == ST_IDLE);
        busy_o       = (r_state != ST_IDLE);
        ram_wren_o   = 1'b0;
        case (r_state)
            ST_PUT, ST_CLEAR: ram_wren_o = ram_grant_i;
`ifdef TEXT_WRITER_SCROLL_EN
            ST_SCROLL_WR:     ram_wren_o = ram_grant_i;
`endif
            default:          ram_wren_o = 1'b0;
        endcase
        w_home = (r_state == ST_CLEAR) && ram_grant_i && w_clr_last && r_full;
        w_cr   = w_xfer && w_is_cr;
        w_lf   = w_xfer && w_is_lf;
        w_back = w_xfer && w_is_bs;
        w_inc  = (r_state == ST_PUT) && ram_grant_i && r_put_adv;
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_addr    <= '0;
            r_data    <= '0;
            r_end_row <= '0;
            r_full    <= 1'b0;
            r_put_adv <= 1'b0;
`ifdef TEXT_WRITER_SCROLL_EN
            r_phase   <= 1'b0;
`endif
        end else if (w_bottom_go) begin
`ifdef TEXT_WRITER_SCROLL_EN
            r_addr  <= {5'd1, 7'd0};
            r_phase <= 1'b0;
`else
            r_addr    <= '0;
            r_data    <= BLANK_CHAR;
            r_end_row <= '0;
            r_full    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: if (w_xfer) begin
                    if (w_is_ff) begin
                        r_addr    <= '0;
                        r_data    <= BLANK_CHAR;
                        r_end_row <= 5'(ROWS - 1);
                        r_full    <= 1'b1;
                    end else if (w_is_prt) begin
                        r_addr    <= {w_row, w_col};
                        r_data    <= char_i;
                        r_put_adv <= 1'b1;
                    end else if (w_is_bs && w_col != '0) begin
                        r_addr    <= {w_row, w_col - 7'd1};
                        r_data    <= BLANK_CHAR;
                        r_put_adv <= 1'b0;
                    end
                end
                ST_CLEAR: if (ram_grant_i && !w_clr_last) r_addr <= w_clr_next;
`ifdef TEXT_WRITER_SCROLL_EN
                // Read needs two granted cycles (address, then data); a gap restarts the cell.
                ST_SCROLL_RD: begin
                    if (!ram_grant_i) r_phase <= 1'b0;
                    else if (!r_phase) r_phase <= 1'b1;
                    else begin
                        r_phase      <= 1'b0;
                        r_data       <= ram_q_i;
                        r_addr[11:7] <= r_addr[11:7] - 5'd1;
                    end
                end
                ST_SCROLL_WR: begin
                    if (!ram_grant_i) r_addr[11:7] <= r_addr[11:7] + 5'd1;
                    else if (w_scr_last) begin
                        r_addr    <= {5'(ROWS - 1), 7'd0};
                        r_data    <= BLANK_CHAR;
                        r_end_row <= 5'(ROWS - 1);
                        r_full    <= 1'b0;
                    end else if (r_addr[6:0] == 7'(COLS - 1)) r_addr <= {r_addr[11:7] + 5'd2, 7'd0};
                    else r_addr <= {r_addr[11:7] + 5'd1, r_addr[6:0] + 7'd1};
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_text_writer.sv
// Bench for text_writer: directed scenarios plus random character streams,
// checked against a screen-level model of cursor rules and screen contents.
`timescale 1ns/1ps
module tb_text_writer;
    localparam int COLS = 80;
    localparam int ROWS = 25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  char_i = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic        grant = 1'b1;
    logic [11:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic [7:0]  ram_q;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    always #5 clk = ~clk;

    text_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK_CHAR(8'h20)) dut (
        .clk(clk), .rst_n_i(rst_n), .char_i(char_i), .char_valid_i(char_valid),
        .char_ready_o(char_ready), .ram_grant_i(grant), .ram_addr_o(ram_addr),
        .ram_data_o(ram_data), .ram_wren_o(ram_wren), .ram_q_i(ram_q),
        .cursor_col_o(cur_col), .cursor_row_o(cur_row), .busy_o(busy)
    );

    // Screen RAM with one-cycle read latency
    logic [7:0]  mem [0:4095];
    int unsigned n_wr = 0;
    logic [11:0] last_wa = '0;
    logic [7:0]  last_wd = '0;
    int unsigned n_bad_wren = 0;
    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr] <= ram_data;
            n_wr    <= n_wr + 1;
            last_wa <= ram_addr;
            last_wd <= ram_data;
        end
        ram_q <= mem[ram_addr];
    end
    always @(negedge clk) if (ram_wren && !grant) n_bad_wren++;

    // Grant pattern: 0 = always, 1 = one high / three low, 2 = random ~75 %
    int gmode = 0;
    initial begin
        int unsigned gcnt = 0;
        forever begin
            @(posedge clk); #1;
            gcnt++;
            case (gmode)
                1:       grant = ((gcnt % 4) == 0);
                2:       grant = ($urandom_range(0, 3) != 0);
                default: grant = 1'b1;
            endcase
        end
    end

    int n_vec = 0;
    int n_mis = 0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: screen as rows x cols, cursor as plain integers
    logic [7:0] mref [ROWS][COLS];
    int mcol = 0;
    int mrow = 0;

    function automatic void m_newline();
        if (mrow == ROWS - 1) begin
`ifdef TEXT_WRITER_SCROLL_EN
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) mref[r][c] = mref[r + 1][c];
            for (int c = 0; c < COLS; c++) mref[ROWS - 1][c] = 8'h20;
`else
            mrow = 0;
            for (int c = 0; c < COLS; c++) mref[0][c] = 8'h20;
`endif
        end else begin
            mrow++;
        end
    endfunction

    function automatic void m_apply(input logic [7:0] ch);
        case (ch)
            8'h08: if (mcol > 0) begin mcol--; mref[mrow][mcol] = 8'h20; end
            8'h0A: m_newline();
            8'h0C: begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) mref[r][c] = 8'h20;
                mcol = 0; mrow = 0;
            end
            8'h0D: mcol = 0;
            default: begin
                mref[mrow][mcol] = ch;
                mcol++;
                if (mcol == COLS) begin mcol = 0; m_newline(); end
            end
        endcase
    endfunction

    function automatic logic [7:0] rand_print();
        logic [7:0] c;
        do c = 8'($urandom_range(0, 255)); while (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D);
        return c;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] ch);
        int t = 0;
        while (!char_ready && t < 40000) begin step(1); t++; end
        if (!char_ready) check("ready_timeout", char_ready, 1);
        char_i = ch; char_valid = 1'b1;
        step(1);
        char_valid = 1'b0;
        m_apply(ch);
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 40000) begin step(1); t++; end
        check(tag, busy, 0);
    endtask

    task automatic check_screen(input string tag);
        int diffs = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (mem[r * 128 + c] !== mref[r][c]) diffs++;
        check({tag, "_cells"}, diffs, 0);
        check({tag, "_col"}, cur_col, mcol);
        check({tag, "_row"}, cur_row, mrow);
    endtask

    function automatic int row_diffs(input int r, input logic [7:0] v);
        int d = 0;
        for (int c = 0; c < COLS; c++) if (mem[r * 128 + c] !== v) d++;
        return d;
    endfunction

    initial begin
        int unsigned w0;
        int rv;
        // Reset state
        step(3);
        check("rst_wren", ram_wren, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_data", ram_data, 0);
        check("rst_busy", busy, 0);
        check("rst_cursor", {cur_row, cur_col}, 0);
        rst_n = 1'b1;
        step(1);
        check("rst_ready", char_ready, 1);

        // Single printable at origin
        w0 = n_wr;
        send(8'h41); wait_idle("a_idle");
        check("a_nwr", n_wr - w0, 1);
        check("a_addr", last_wa, 12'h000);
        check("a_data", last_wd, 8'h41);
        check("a_cursor", {cur_row, cur_col}, {5'd0, 7'd1});

        // Last column wraps to next row
        send(8'h0D);
        for (int i = 0; i < 3; i++) send(8'h0A);
        for (int i = 0; i < 79; i++) send(rand_print());
        wait_idle("b_idle");
        check("b_pre_cursor", {cur_row, cur_col}, {5'd3, 7'd79});
        w0 = n_wr;
        send(8'h42); wait_idle("b_idle2");
        check("b_nwr", n_wr - w0, 1);
        check("b_addr", last_wa, {5'd3, 7'd79});
        check("b_cursor", {cur_row, cur_col}, {5'd4, 7'd0});

        // Form feed, then backspace / carriage return
        send(8'h0C); wait_idle("c_ff_idle");
        check_screen("c_ff");
        send(8'h0A); send(8'h0A);
        for (int i = 0; i < 5; i++) send(rand_print());
        wait_idle("c_idle");
        check("c_pre_cursor", {cur_row, cur_col}, {5'd2, 7'd5});
        w0 = n_wr;
        send(8'h08); wait_idle("c_bs_idle");
        check("c_bs_nwr", n_wr - w0, 1);
        check("c_bs_addr", last_wa, {5'd2, 7'd4});
        check("c_bs_data", last_wd, 8'h20);
        check("c_bs_cursor", {cur_row, cur_col}, {5'd2, 7'd4});
        w0 = n_wr;
        send(8'h0D); wait_idle("c_cr_idle");
        check("c_cr_cursor", {cur_row, cur_col}, {5'd2, 7'd0});
        send(8'h08); wait_idle("c_bs0_idle");
        check("c_cr_bs0_nwr", n_wr - w0, 0);
        check("c_bs0_cursor", {cur_row, cur_col}, {5'd2, 7'd0});

        // Clear under sparse grant
        gmode = 1;
        send(8'h0C); wait_idle("d_idle");
        gmode = 0;
        rv = 0;
        for (int r = 0; r < ROWS; r++) rv += row_diffs(r, 8'h20);
        check("d_blank_cells", rv, 0);
        check("d_cursor", {cur_row, cur_col}, 0);
        check("d_wren_nogrant", n_bad_wren, 0);

        // Random stream, no form feeds
        gmode = 2;
        for (int i = 0; i < 60; i++) begin
            rv = $urandom_range(0, 99);
            if (rv < 70)      send(rand_print());
            else if (rv < 82) send(8'h0A);
            else if (rv < 90) send(8'h0D);
            else              send(8'h08);
        end
        wait_idle("e_idle");
        check_screen("e");
        gmode = 0;

        // Line feed on the last row
        send(8'h0C); send(8'h0A);
        for (int i = 0; i < COLS; i++) send(8'h55);
        while (mrow != ROWS - 1) send(8'h0A);
        send(8'h0D); wait_idle("f_pre_idle");
        check("f_pre_cursor", {cur_row, cur_col}, {5'd24, 7'd0});
        send(8'h0A); wait_idle("f_idle");
`ifdef TEXT_WRITER_SCROLL_EN
        check("f_row0_55", row_diffs(0, 8'h55), 0);
        check("f_row24_blank", row_diffs(24, 8'h20), 0);
        check("f_cursor", {cur_row, cur_col}, {5'd24, 7'd0});
`else
        check("f_row0_blank", row_diffs(0, 8'h20), 0);
        check("f_cursor", {cur_row, cur_col}, 0);
`endif
        check_screen("f");

        // Printable wrap past the last row under random grant
        gmode = 2;
        send(8'h0D);
        while (mrow != ROWS - 1) send(8'h0A);
        for (int i = 0; i < COLS; i++) send(rand_print());
        wait_idle("g_idle");
        check_screen("g");
        gmode = 0;

        // Reset while the bottom-of-screen sequence is running
        while (mrow != ROWS - 1) send(8'h0A);
        wait_idle("h_pre_idle");
        send(8'h0A);
        step(30);
        check("h_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("h_wren", ram_wren, 0);
        check("h_busy", busy, 0);
        check("h_cursor", {cur_row, cur_col}, 0);
        check("h_addr", ram_addr, 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        check("h_ready", char_ready, 1);
        check("wren_nogrant_total", n_bad_wren, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
